uart_receiver: RTL and testbench
================================

# uart_receiver

Serial UART receiver (8 data bits, LSB first, 1 stop bit) for the microcontroller's `uart_rx` pin. It is the receive-side counterpart of the UART transmitter driving `uart_tx`. It deserializes incoming frames, buffers complete bytes in a small FIFO and presents them to the peripheral bus logic over a valid/ready stream. It also flags framing errors and overruns, and parity errors when parity is compiled in.

## Interface
Parameters:
- `CLK_DIV`, default 16: clock cycles per bit period; legal values ≥ 4.
- `FIFO_DEPTH`, default 4: receive buffer entries; must be a power of two, ≥ 2.

Ports (reset is asynchronous, active-low):
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial input, asynchronous to `clk`; idle high.
- `rd_valid`  out  1  FIFO non-empty; `rd_data` holds the oldest byte.
- `rd_data`  out  8  head-of-FIFO byte.
- `rd_ready`  in  1  consumer accepts; pop occurs when `rd_valid && rd_ready`.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- `parity_err`  out  1  one-cycle pulse on parity mismatch; tied 0 without `UART_RX_PARITY_EN`.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- Start is detected on the synchronized falling edge: the sync output is 0 and the previous value was 1.
- The receiver FSM has these states:
  - IDLE → START on start detect; the bit counter loads `CLK_DIV/2` (floor).
  - START: at expiry, if the line is still 0, go to DATA. If it is 1, treat it as a glitch and return to IDLE with no error.
  - DATA: sample every `CLK_DIV` cycles into a shift register, LSB first. After 8 samples, go to PARITY (macro on) or STOP.
  - PARITY: sample one bit and compare it against the XOR of the 8 data bits (even parity).
  - STOP: sample one bit.
    - Sample 1 and no parity error: push the byte.
    - Sample 1 with a parity error: pulse `parity_err`, discard the byte, go to IDLE.
    - Sample 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronized line is 1, then go to IDLE. No start detect happens in this state.
- `frame_err` takes priority. With parity on, a bad stop bit raises only `frame_err`.
- FIFO write and read behaviour:
  - A push to a full FIFO with no simultaneous pop drops the new byte and pulses `overrun`.
  - A simultaneous push and pop when full is accepted: no overrun, and the count is unchanged.
  - A push and pop together in any other state leaves the count unchanged.
- FIFO pointers wrap modulo `FIFO_DEPTH`. A count register of width `$clog2(FIFO_DEPTH)+1` distinguishes full from empty.
- `rd_data` is 0 when the FIFO is empty.

## Timing
- Define t0 as the cycle start detect is registered. This is 2–3 cycles after the physical `rx` edge, because of the synchronizer.
- Sample instants, with H = `CLK_DIV/2`:
  - start check at t0+H;
  - data bit i (i = 0..7) at t0+H+(i+1)·`CLK_DIV`;
  - parity bit at t0+H+9·`CLK_DIV`;
  - stop bit at t0+H+9·`CLK_DIV` (no parity) or t0+H+10·`CLK_DIV` (parity).
- FIFO write and the error pulses occur on the stop-sample cycle. `rd_valid` rises the following cycle.
- A new start detect is possible the cycle after the stop sample returns the FSM to IDLE. Back-to-back frames are received without loss.
- Pop takes effect at the clock edge. `rd_valid`/`rd_data` reflect the next entry one cycle later, with no bubble when more data is queued.
- Reset is asynchronous and takes effect mid-frame. It immediately sets:
  - `rd_valid`, `rd_data`, all error pulses and the FIFO count to 0;
  - the FSM to IDLE;
  - the synchronizer flops to 1.
- The partially received frame is lost. The first frame after reset release is received normally.

## Configuration
- `UART_RX_PARITY_EN`, when defined:
  - frames are 8E1;
  - the PARITY state exists;
  - `parity_err` is live.
- When undefined:
  - frames are 8N1;
  - the PARITY state and parity XOR are not compiled;
  - `parity_err` is a constant 0.
- Port list is identical in both builds.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - `UART_DATA_BITS` = 8;
  - `UART_MIN_CLK_DIV` = 4.
- The UART transmitter shares `uart_pkg`.
- Sub-module `uart_rx_fifo` is a synchronous FIFO with push/pop/full/empty, parameterized by depth and width.
- `uart_receiver` contains the synchronizer, FSM, bit/baud counters and error logic.

## Test plan
All cases use `CLK_DIV`=16, `FIFO_DEPTH`=4, parity off unless stated.
- Send 0xA5 → `rd_valid` rises at t0+153 with `rd_data`=0xA5; hold `rd_ready`=1 → `rd_valid` drops the next cycle; all error outputs stay 0.
- Drive `rx` low for 4 cycles, then high → no byte and no error; FSM back in IDLE; a following 0x3C is received correctly.
- Send 0x3C with stop bit 0, then hold `rx` low 40 cycles → one `frame_err` pulse and the FIFO stays empty; after `rx` goes high, 0x11 is received correctly.
- With `rd_ready`=0, send 0x01..0x05 back-to-back → one `overrun` pulse at the fifth stop sample; draining yields 0x01, 0x02, 0x03, 0x04, then `rd_valid`=0.
- With the macro on, send 0x07 with parity bit 0 → `parity_err` pulse and no byte; 0x07 with parity bit 1 → byte accepted.
- Assert `reset` during data bit 3 of 0x96 → all outputs 0 asynchronously; after release, 0x5A is received correctly and 0x96 never appears.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame constants.
// Used by both the receive and transmit sides.
package uart_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_MIN_CLK_DIV = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO: push/pop, full/empty, zero on rdata when empty.
// Ports: clk, rst_n, push, pop, wdata, rdata, full, empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // A pop frees the slot in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN), FIFO-buffered.
// Ports: clk, reset(n), rx, rd_valid/rd_data/rd_ready, error pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  // Clamp to the shortest bit period the half-bit start check supports.
  localparam int DIV = (CLK_DIV < UART_MIN_CLK_DIV) ?
                       UART_MIN_CLK_DIV : CLK_DIV;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [2:0]    BMAX = 3'(UART_DATA_BITS - 1);

  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic start_det;

  uart_rx_state_e state;
  uart_rx_state_e state_n;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;
  logic [2:0]     bit_idx;
  logic [2:0]     bit_idx_n;
  logic [7:0]     shreg;
  logic [7:0]     shreg_n;
  logic           tick;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;
`ifdef UART_RX_PARITY_EN
  logic           par_bad;
  logic           par_bad_n;
  logic           par_hit;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_det = !rx_sync && rx_prev;
  assign tick      = cnt == '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = tick ? cnt : cnt - 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    par_hit   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (start_det) begin
          state_n = START;
          cnt_n   = HALF;
        end
      end
      START: begin
        if (tick) begin
          // A start bit gone high by mid-bit is a glitch.
          if (!rx_sync) begin
            state_n   = DATA;
            cnt_n     = LAST;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_n   = {rx_sync, shreg[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          cnt_n     = LAST;
          if (bit_idx == BMAX) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_bad_n = rx_sync ^ (^shreg);
          cnt_n     = LAST;
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_n = IDLE;
          if (!rx_sync) begin
            frame_err = 1'b1;
            state_n   = WAIT_IDLE;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bad) begin
            par_hit = 1'b1;
          end
`endif
          else begin
            push = 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = par_hit;
`else
  assign parity_err = 1'b0;
`endif

  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready;
  assign overrun  = push && full && !pop;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .wdata (shreg),
    .rdata (rd_data),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver (CLK_DIV=16, FIFO_DEPTH=4).
// Builds 8E1 frames when UART_RX_PARITY_EN is defined.
module tb_uart_receiver;

  localparam int D     = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Physical start edge -> rd_valid high: 3 sync/detect cycles,
  // half bit, 9 (or 10) bit periods, then one cycle to register.
  localparam int RISE = 3 + D / 2 + (9 + PB) * D + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_receiver #(
    .CLK_DIV    (D),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int n_fe, n_ov, n_pe;
  int rise_cyc, fall_cyc, t_start;
  logic [7:0] rise_data;
  logic v_q = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (frame_err)  n_fe++;
    if (overrun)    n_ov++;
    if (parity_err) n_pe++;
    if (rd_valid && !v_q) begin
      rise_cyc  = cyc;
      rise_data = rd_data;
    end
    if (!rd_valid && v_q) fall_cyc = cyc;
    if (rd_valid && rd_ready) got_q.push_back(rd_data);
    v_q = rd_valid;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  function automatic logic par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic clear();
    n_fe = 0; n_ov = 0; n_pe = 0;
    rise_cyc = -1; fall_cyc = -1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic stop,
                      input logic pbit);
    @(posedge clk); #1 rx = 1'b0; t_start = cyc;
    repeat (D) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = d[i];
      repeat (D) @(posedge clk);
    end
    if (PB == 1) begin
      #1 rx = pbit;
      repeat (D) @(posedge clk);
    end
    #1 rx = stop;
    repeat (D) @(posedge clk);
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 600 && got_q.size() < n; i++)
      @(posedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1 rd_ready = r;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (rd_valid !== 1'b0)
      $display("FAIL rst_valid: got %b want 0", rd_valid);
    else n_pass++;
    n_chk++; if (rd_data !== 8'h00)
      $display("FAIL rst_data: got %h want 00", rd_data);
    else n_pass++;
    n_chk++; if ({frame_err, overrun, parity_err} !== 3'b000)
      $display("FAIL rst_errs: got %b want 000",
               {frame_err, overrun, parity_err});
    else n_pass++;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_chk++; if (rd_valid !== 1'b0)
      $display("FAIL post_rst_valid: got %b want 0", rd_valid);
    else n_pass++;
  endtask

  task automatic test_single();
    int dt;
    set_ready(1'b1);
    clear();
    send(8'hA5, 1'b1, par(8'hA5));
    repeat (10) @(posedge clk);
    dt = rise_cyc - t_start;
    n_chk++; if (dt < RISE - 1 || dt > RISE)
      $display("FAIL single_latency: got %0d want %0d..%0d",
               dt, RISE - 1, RISE);
    else n_pass++;
    n_chk++; if (rise_data !== 8'hA5)
      $display("FAIL single_data: got %h want a5", rise_data);
    else n_pass++;
    n_chk++; if (fall_cyc !== rise_cyc + 1)
      $display("FAIL single_pop: fall %0d want %0d",
               fall_cyc, rise_cyc + 1);
    else n_pass++;
    n_chk++; if (n_fe + n_ov + n_pe !== 0)
      $display("FAIL single_errs: got %0d want 0",
               n_fe + n_ov + n_pe);
    else n_pass++;
  endtask

  task automatic test_glitch();
    clear();
    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    n_chk++; if (got_q.size() !== 0 || n_fe + n_pe !== 0)
      $display("FAIL glitch_quiet: bytes %0d errs %0d want 0 0",
               got_q.size(), n_fe + n_pe);
    else n_pass++;
    send(8'h3C, 1'b1, par(8'h3C));
    wait_got(1);
    n_chk++; if (got_q.size() !== 1 || got_q[0] !== 8'h3C)
      $display("FAIL glitch_next: n %0d byte %h want 1 3c",
               got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    else n_pass++;
  endtask

  task automatic test_frame_err();
    clear();
    // Wrong parity too: the framing error alone must be reported.
    send(8'h3C, 1'b0, ~par(8'h3C));
    repeat (40) @(posedge clk);
    n_chk++; if (n_fe !== 1 || n_pe !== 0)
      $display("FAIL ferr_pulse: fe %0d pe %0d want 1 0", n_fe, n_pe);
    else n_pass++;
    n_chk++; if (got_q.size() !== 0 || rd_valid !== 1'b0)
      $display("FAIL ferr_empty: bytes %0d valid %b want 0 0",
               got_q.size(), rd_valid);
    else n_pass++;
    #1 rx = 1'b1;
    repeat (20) @(posedge clk);
    send(8'h11, 1'b1, par(8'h11));
    wait_got(1);
    n_chk++; if (got_q.size() !== 1 || got_q[0] !== 8'h11 || n_fe !== 1)
      $display("FAIL ferr_next: n %0d byte %h fe %0d want 1 11 1",
               got_q.size(), got_q.size() ? got_q[0] : 8'h00, n_fe);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int exp_ov = 0;
    set_ready(1'b0);
    clear();
    for (int b = 1; b <= 5; b++) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(b));
      else exp_ov++;
      send(8'(b), 1'b1, par(8'(b)));
    end
    repeat (5) @(posedge clk);
    n_chk++; if (n_ov !== exp_ov || rd_valid !== 1'b1)
      $display("FAIL ovr_pulse: ov %0d valid %b want %0d 1",
               n_ov, rd_valid, exp_ov);
    else n_pass++;
    set_ready(1'b1);
    wait_got(exp_q.size());
    repeat (5) @(posedge clk);
    n_chk++; if (got_q.size() !== exp_q.size())
      $display("FAIL ovr_count: got %0d want %0d",
               got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i])
        $display("FAIL ovr_order[%0d]: got %h want %h",
                 i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_chk++; if (rd_valid !== 1'b0 || rd_data !== 8'h00)
      $display("FAIL ovr_drained: valid %b data %h want 0 00",
               rd_valid, rd_data);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] d;
    set_ready(1'b1);
    clear();
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      exp_q.push_back(d);
      send(d, 1'b1, par(d));
    end
    wait_got(exp_q.size());
    n_chk++; if (got_q.size() !== exp_q.size())
      $display("FAIL rand_count: got %0d want %0d",
               got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i])
        $display("FAIL rand_byte[%0d]: got %h want %h",
                 i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_chk++; if (n_fe + n_ov + n_pe !== 0)
      $display("FAIL rand_errs: got %0d want 0", n_fe + n_ov + n_pe);
    else n_pass++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    set_ready(1'b1);
    clear();
    send(8'h07, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    n_chk++; if (n_pe !== 1 || got_q.size() !== 0)
      $display("FAIL par_bad: pe %0d bytes %0d want 1 0",
               n_pe, got_q.size());
    else n_pass++;
    send(8'h07, 1'b1, 1'b1);
    wait_got(1);
    n_chk++; if (got_q.size() !== 1 || got_q[0] !== 8'h07 || n_pe !== 1)
      $display("FAIL par_good: n %0d byte %h pe %0d want 1 07 1",
               got_q.size(), got_q.size() ? got_q[0] : 8'h00, n_pe);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid();
    set_ready(1'b0);
    clear();
    send(8'h22, 1'b1, par(8'h22));
    repeat (3) @(posedge clk);
    n_chk++; if (rd_valid !== 1'b1)
      $display("FAIL rmid_pre: valid %b want 1", rd_valid);
    else n_pass++;
    fork
      send(8'h96, 1'b1, par(8'h96));
      begin
        repeat (4 * D + 6) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        n_chk++; if (rd_valid !== 1'b0 || rd_data !== 8'h00)
          $display("FAIL rmid_async: valid %b data %h want 0 00",
                   rd_valid, rd_data);
        else n_pass++;
        n_chk++; if ({frame_err, overrun, parity_err} !== 3'b000)
          $display("FAIL rmid_errs: got %b want 000",
                   {frame_err, overrun, parity_err});
        else n_pass++;
      end
    join
    @(posedge clk); #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    set_ready(1'b1);
    send(8'h5A, 1'b1, par(8'h5A));
    wait_got(1);
    repeat (20) @(posedge clk);
    n_chk++; if (got_q.size() !== 1 || got_q[0] !== 8'h5A)
      $display("FAIL rmid_after: n %0d byte %h want 1 5a",
               got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
